// File: rtl/slurm16_memory_arbiter.sv
// rtl/slurm16_memory_arbiter.sv - three-port SRAM arbiter (data, fetch, DMA) with registered command path
module slurm16_memory_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_wr_mask,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [15:0] d_rdata,
  output logic        d_success,
  input  logic [14:0] i_addr,
  input  logic        i_rd,
  output logic [15:0] i_rdata,
  output logic        i_success,
  input  logic [14:0] m_addr,
  input  logic [15:0] m_wdata,
  input  logic        m_rd,
  input  logic        m_wr,
  output logic [15:0] m_rdata,
  output logic        m_success,
  output logic [14:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic [1:0]  sram_wr_mask,
  output logic        sram_rd,
  output logic        sram_wr,
  input  logic [15:0] sram_rdata
);

  localparam logic [1:0] ID_DATA  = 2'd0;
  localparam logic [1:0] ID_FETCH = 2'd1;
  localparam logic [1:0] ID_DMA   = 2'd2;

  function automatic logic [1:0] next_id(input logic [1:0] x);
    return (x == ID_DMA) ? ID_DATA : x + 2'd1;
  endfunction

  logic [1:0]  p_q, p_d;
  logic        own1_v_q, own1_v_d, own2_v_q, own2_v_d;
  logic [1:0]  own1_id_q, own1_id_d, own2_id_q, own2_id_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  mask_q, mask_d;
  logic        rd_q, rd_d, wr_q, wr_d;

  logic [2:0]  req, busy, elig;
  logic        gnt_v;
  logic [1:0]  gnt_id, idx;
  logic        unused_d_addr_lsb;

  assign unused_d_addr_lsb = d_addr[0];

  always_comb begin
    req  = {m_rd | m_wr, i_rd, d_rd | d_wr};
    busy = 3'b000;
    for (int k = 0; k < 3; k++) begin
      busy[k] = (own1_v_q && own1_id_q == 2'(k)) || (own2_v_q && own2_id_q == 2'(k));
    end
    elig = req & ~busy;

    gnt_v  = 1'b0;
    gnt_id = ID_DATA;
    idx    = p_q;
    if (ROUND_ROBIN) begin
      for (int off = 0; off < 3; off++) begin
        if (!gnt_v && elig[idx]) begin
          gnt_v  = 1'b1;
          gnt_id = idx;
        end
        idx = next_id(idx);
      end
    end else begin
      if (elig[0]) begin
        gnt_v = 1'b1; gnt_id = ID_DATA;
      end else if (elig[1]) begin
        gnt_v = 1'b1; gnt_id = ID_FETCH;
      end else if (elig[2]) begin
        gnt_v = 1'b1; gnt_id = ID_DMA;
      end
    end

    p_d = (ROUND_ROBIN && gnt_v) ? next_id(gnt_id) : p_q;

    // Address/data hold when idle; only the strobes must return to zero.
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    if (gnt_v) begin
      case (gnt_id)
        ID_DATA: begin
          addr_d  = d_addr[15:1];
          wdata_d = d_wdata;
          wr_d    = d_wr;
          rd_d    = !d_wr;
          mask_d  = d_wr ? d_wr_mask : 2'b00;
        end
        ID_FETCH: begin
          addr_d = i_addr;
          rd_d   = 1'b1;
          mask_d = 2'b00;
        end
        default: begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wr_d    = m_wr;
          rd_d    = !m_wr;
          mask_d  = m_wr ? 2'b11 : 2'b00;
        end
      endcase
    end

    own1_v_d  = gnt_v;
    own1_id_d = gnt_id;
    own2_v_d  = own1_v_q;
    own2_id_d = own1_id_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q       <= ID_DATA;
      own1_v_q  <= 1'b0;
      own1_id_q <= 2'd0;
      own2_v_q  <= 1'b0;
      own2_id_q <= 2'd0;
      addr_q    <= 15'd0;
      wdata_q   <= 16'd0;
      mask_q    <= 2'b00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      p_q       <= p_d;
      own1_v_q  <= own1_v_d;
      own1_id_q <= own1_id_d;
      own2_v_q  <= own2_v_d;
      own2_id_q <= own2_id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign sram_wr_mask = mask_q;
  assign sram_rd      = rd_q;
  assign sram_wr      = wr_q;

  assign d_success = own2_v_q && (own2_id_q == ID_DATA);
  assign i_success = own2_v_q && (own2_id_q == ID_FETCH);
  assign m_success = own2_v_q && (own2_id_q == ID_DMA);

  assign d_rdata = sram_rdata;
  assign i_rdata = sram_rdata;
  assign m_rdata = sram_rdata;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// tb/tb_slurm16_memory_arbiter.sv - directed bench for slurm16_memory_arbiter, both arbitration modes
module tb_slurm16_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] d_addr, d_wdata;
  logic [1:0]  d_wr_mask;
  logic        d_rd, d_wr;
  logic [14:0] i_addr;
  logic        i_rd;
  logic [14:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd, m_wr;
  logic [15:0] sram_rdata;

  logic [15:0] d_rdata_r, i_rdata_r, m_rdata_r, sram_wdata_r;
  logic        d_success_r, i_success_r, m_success_r, sram_rd_r, sram_wr_r;
  logic [14:0] sram_addr_r;
  logic [1:0]  sram_wr_mask_r;
  logic [15:0] d_rdata_f, i_rdata_f, m_rdata_f, sram_wdata_f;
  logic        d_success_f, i_success_f, m_success_f, sram_rd_f, sram_wr_f;
  logic [14:0] sram_addr_f;
  logic [1:0]  sram_wr_mask_f;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  slurm16_memory_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .CLK(CLK), .RST(RST),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_mask(d_wr_mask), .d_rd(d_rd), .d_wr(d_wr),
    .d_rdata(d_rdata_r), .d_success(d_success_r),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata_r), .i_success(i_success_r),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata_r), .m_success(m_success_r),
    .sram_addr(sram_addr_r), .sram_wdata(sram_wdata_r), .sram_wr_mask(sram_wr_mask_r),
    .sram_rd(sram_rd_r), .sram_wr(sram_wr_r), .sram_rdata(sram_rdata)
  );

  slurm16_memory_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
    .CLK(CLK), .RST(RST),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_mask(d_wr_mask), .d_rd(d_rd), .d_wr(d_wr),
    .d_rdata(d_rdata_f), .d_success(d_success_f),
    .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata_f), .i_success(i_success_f),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata_f), .m_success(m_success_f),
    .sram_addr(sram_addr_f), .sram_wdata(sram_wdata_f), .sram_wr_mask(sram_wr_mask_f),
    .sram_rd(sram_rd_f), .sram_wr(sram_wr_f), .sram_rdata(sram_rdata)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drop_all();
    d_rd = 1'b0; d_wr = 1'b0; i_rd = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drop_all();
    d_addr = 16'h0; d_wdata = 16'h0; d_wr_mask = 2'b00;
    i_addr = 15'h0; m_addr = 15'h0; m_wdata = 16'h0; sram_rdata = 16'h0;
    tick(); tick();
    n_checks++;
    if ({d_success_r, i_success_r, m_success_r, sram_rd_r, sram_wr_r} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=00000", {d_success_r, i_success_r, m_success_r, sram_rd_r, sram_wr_r});
    end
    n_checks++;
    if ({sram_addr_r, sram_wdata_r, sram_wr_mask_r} !== 33'd0) begin
      n_fail++; $display("FAIL reset_cmd got=%h exp=0", {sram_addr_r, sram_wdata_r, sram_wr_mask_r});
    end
    n_checks++;
    if ({d_success_f, i_success_f, m_success_f, sram_rd_f, sram_wr_f} !== 5'b0) begin
      n_fail++; $display("FAIL reset_fp_strobes got=%b exp=00000", {d_success_f, i_success_f, m_success_f, sram_rd_f, sram_wr_f});
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    sram_rdata = 16'h5A5A;
    d_addr = 16'h1234; d_rd = 1'b1;
    tick();
    n_checks++;
    if ({sram_rd_r, sram_wr_r, sram_addr_r, sram_wr_mask_r} !== {1'b1, 1'b0, 15'h091A, 2'b00}) begin
      n_fail++; $display("FAIL rd_cmd got rd=%b wr=%b addr=%h mask=%b exp rd=1 wr=0 addr=091a mask=00", sram_rd_r, sram_wr_r, sram_addr_r, sram_wr_mask_r);
    end
    n_checks++;
    if (d_success_r !== 1'b0) begin
      n_fail++; $display("FAIL rd_early_success got=%b exp=0", d_success_r);
    end
    tick();
    n_checks++;
    if ({d_success_r, i_success_r, m_success_r} !== 3'b100 || d_rdata_r !== 16'h5A5A) begin
      n_fail++; $display("FAIL rd_success got=%b data=%h exp=100 data=5a5a", {d_success_r, i_success_r, m_success_r}, d_rdata_r);
    end
    n_checks++;
    if (sram_rd_r !== 1'b0) begin
      n_fail++; $display("FAIL rd_masked_regrant got sram_rd=%b exp=0", sram_rd_r);
    end
    d_rd = 1'b0;
    tick();
    n_checks++;
    if (d_success_r !== 1'b0) begin
      n_fail++; $display("FAIL rd_pulse_width got=%b exp=0", d_success_r);
    end
  endtask

  task automatic test_write();
    d_addr = 16'h0010; d_wdata = 16'hBEEF; d_wr_mask = 2'b10; d_wr = 1'b1;
    tick();
    n_checks++;
    if ({sram_wr_r, sram_rd_r, sram_addr_r, sram_wr_mask_r, sram_wdata_r} !== {1'b1, 1'b0, 15'h0008, 2'b10, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_cmd got wr=%b rd=%b addr=%h mask=%b wdata=%h exp 1 0 0008 10 beef", sram_wr_r, sram_rd_r, sram_addr_r, sram_wr_mask_r, sram_wdata_r);
    end
    tick();
    n_checks++;
    if ({d_success_r, i_success_r, m_success_r} !== 3'b100) begin
      n_fail++; $display("FAIL wr_success got=%b exp=100", {d_success_r, i_success_r, m_success_r});
    end
    d_wr = 1'b0;
    tick();
  endtask

  task automatic test_dma_rd_wr();
    m_addr = 15'h7FFF; m_wdata = 16'h1234; m_rd = 1'b1; m_wr = 1'b1;
    tick();
    n_checks++;
    if ({sram_wr_r, sram_rd_r, sram_addr_r, sram_wr_mask_r, sram_wdata_r} !== {1'b1, 1'b0, 15'h7FFF, 2'b11, 16'h1234}) begin
      n_fail++; $display("FAIL dma_cmd got wr=%b rd=%b addr=%h mask=%b wdata=%h exp 1 0 7fff 11 1234", sram_wr_r, sram_rd_r, sram_addr_r, sram_wr_mask_r, sram_wdata_r);
    end
    tick();
    n_checks++;
    if ({d_success_r, i_success_r, m_success_r} !== 3'b001) begin
      n_fail++; $display("FAIL dma_success got=%b exp=001", {d_success_r, i_success_r, m_success_r});
    end
    m_rd = 1'b0; m_wr = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp_addr [3];
    logic [2:0]  exp_succ [3];
    exp_addr[0] = 15'h0001; exp_addr[1] = 15'h0002; exp_addr[2] = 15'h0003;
    exp_succ[0] = 3'b100;   exp_succ[1] = 3'b010;   exp_succ[2] = 3'b001;
    d_addr = 16'h0002; i_addr = 15'h0002; m_addr = 15'h0003;
    d_rd = 1'b1; i_rd = 1'b1; m_rd = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (sram_rd_r !== 1'b1 || sram_addr_r !== exp_addr[(k-1)%3]) begin
        n_fail++; $display("FAIL b2b_rr_cmd cycle=%0d got rd=%b addr=%h exp rd=1 addr=%h", k, sram_rd_r, sram_addr_r, exp_addr[(k-1)%3]);
      end
      n_checks++;
      if (sram_rd_f !== 1'b1 || sram_addr_f !== exp_addr[(k-1)%3]) begin
        n_fail++; $display("FAIL b2b_fp_cmd cycle=%0d got rd=%b addr=%h exp rd=1 addr=%h", k, sram_rd_f, sram_addr_f, exp_addr[(k-1)%3]);
      end
      if (k >= 2) begin
        n_checks++;
        if ({d_success_r, i_success_r, m_success_r} !== exp_succ[(k-2)%3] ||
            {d_success_f, i_success_f, m_success_f} !== exp_succ[(k-2)%3]) begin
          n_fail++; $display("FAIL b2b_success cycle=%0d got rr=%b fp=%b exp=%b", k,
                             {d_success_r, i_success_r, m_success_r}, {d_success_f, i_success_f, m_success_f}, exp_succ[(k-2)%3]);
        end
      end
    end
    drop_all();
    tick(); tick(); tick();
  endtask

  task automatic test_fixed_two_ports();
    logic       exp_rd   [3];
    logic [14:0] exp_addr [3];
    exp_rd[0] = 1'b1; exp_rd[1] = 1'b1; exp_rd[2] = 1'b0;
    exp_addr[0] = 15'h0011; exp_addr[1] = 15'h0022;
    d_addr = 16'h0022; i_addr = 15'h0022;
    d_rd = 1'b1; i_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (sram_rd_f !== exp_rd[(k-1)%3]) begin
        n_fail++; $display("FAIL fp_two_strobe cycle=%0d got=%b exp=%b", k, sram_rd_f, exp_rd[(k-1)%3]);
      end
      if (exp_rd[(k-1)%3]) begin
        n_checks++;
        if (sram_addr_f !== exp_addr[(k-1)%3]) begin
          n_fail++; $display("FAIL fp_two_addr cycle=%0d got=%h exp=%h", k, sram_addr_f, exp_addr[(k-1)%3]);
        end
      end
    end
    drop_all();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    d_addr = 16'h0040; d_wdata = 16'hCAFE; d_wr_mask = 2'b11; d_wr = 1'b1;
    tick();
    n_checks++;
    if (sram_wr_r !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre_wr got=%b exp=1", sram_wr_r);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (sram_wr_r !== 1'b0 || sram_wr_f !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async_wr got rr=%b fp=%b exp=0", sram_wr_r, sram_wr_f);
    end
    d_wr = 1'b0;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (d_success_r !== 1'b0 || d_success_f !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_lost_success cycle=%0d got rr=%b fp=%b exp=0", k, d_success_r, d_success_f);
      end
      tick();
    end
    d_addr = 16'h0100; i_addr = 15'h0200; m_addr = 15'h0300;
    d_rd = 1'b1; i_rd = 1'b1; m_rd = 1'b1;
    tick();
    n_checks++;
    if (sram_rd_r !== 1'b1 || sram_addr_r !== 15'h0080) begin
      n_fail++; $display("FAIL rst_mid_pointer got rd=%b addr=%h exp rd=1 addr=0080", sram_rd_r, sram_addr_r);
    end
    tick();
    n_checks++;
    if (sram_addr_r !== 15'h0200 || d_success_r !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_resume got addr=%h d_success=%b exp addr=0200 d_success=1", sram_addr_r, d_success_r);
    end
    drop_all();
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_dma_rd_wr();
    test_back_to_back();
    test_fixed_two_ports();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
